// File: rtl/regfile_pe_mp.sv
// Multi-port PE register file with two byte-enabled write ports, NUM_RD read
// ports, an optional read register, optional write-to-read forwarding and a
// sequenced clear sweep that zeroes one entry per cycle.
module regfile_pe_mp #(
  parameter int AWIDTH   = 3,
  parameter int DWIDTH   = 32,
  parameter int NUM_RD   = 2,
  parameter int REG_READ = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [1:0]                 Write_En,
  input  logic [2*AWIDTH-1:0]        Write_Addr,
  input  logic [2*DWIDTH-1:0]        Write_Data,
  input  logic [2*(DWIDTH/8)-1:0]    Write_BE,
  input  logic [NUM_RD-1:0]          Read_En,
  input  logic [NUM_RD*AWIDTH-1:0]   Read_Addr,
  output logic [NUM_RD*DWIDTH-1:0]   Read_Data,
  input  logic                       Clear_Req,
  output logic                       Clear_Busy
);

  localparam int NUM_REGS = 2**AWIDTH;
  localparam int NB       = DWIDTH/8;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DWIDTH-1:0]   mem_q [NUM_REGS];
  logic [DWIDTH-1:0]   view_data [NUM_RD];
  logic                idle;

  assign idle       = (state_q == ST_IDLE);
  assign Clear_Busy = (state_q == ST_CLEAR);

  // Clear FSM state and sweep counter registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // flop samples pre-edge values regardless of block evaluation order.
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Clear FSM next-state: sweep every entry once, ignore requests while busy.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        clr_cnt_d = '0;
        if (Clear_Req) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (clr_cnt_q == AWIDTH'(NUM_REGS-1)) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Storage: async reset to zero, sweep clear, or byte-enabled writes.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      // NOTE: the file is built from flops rather than a RAM macro because it
      // must read as zero straight out of reset, so every entry is reset here.
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (!idle) begin
      mem_q[clr_cnt_q] <= '0;
    end else begin
      // WP1 is visited after WP0, so its byte update is the one that lands.
      for (int p = 0; p < 2; p++) begin
        for (int b = 0; b < NB; b++) begin
          if (Write_En[p] && Write_BE[p*NB+b])
            mem_q[Write_Addr[p*AWIDTH +: AWIDTH]][b*8 +: 8] <= Write_Data[p*DWIDTH + b*8 +: 8];
        end
      end
    end
  end

  // Write-view per read port: memory overlaid with this cycle's writes,
  // using the same WP1-over-WP0 byte priority as the storage update.
  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      view_data[r] = mem_q[Read_Addr[r*AWIDTH +: AWIDTH]];
      if (BYPASS != 0 && idle) begin
        for (int p = 0; p < 2; p++) begin
          for (int b = 0; b < NB; b++) begin
            if (Write_En[p] && Write_BE[p*NB+b] &&
                Write_Addr[p*AWIDTH +: AWIDTH] == Read_Addr[r*AWIDTH +: AWIDTH])
              view_data[r][b*8 +: 8] = Write_Data[p*DWIDTH + b*8 +: 8];
          end
        end
      end
    end
  end

  generate
    if (REG_READ != 0) begin : g_reg_read
      logic [DWIDTH-1:0] rd_q [NUM_RD];

      // Registered read data: capture on enable, hold otherwise.
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          for (int r = 0; r < NUM_RD; r++) rd_q[r] <= '0;
        end else begin
          for (int r = 0; r < NUM_RD; r++)
            if (Read_En[r]) rd_q[r] <= view_data[r];
        end
      end

      for (genvar r = 0; r < NUM_RD; r++) begin : g_out
        assign Read_Data[r*DWIDTH +: DWIDTH] = rd_q[r];
      end
    end else begin : g_comb_read
      for (genvar r = 0; r < NUM_RD; r++) begin : g_out
        assign Read_Data[r*DWIDTH +: DWIDTH] = Read_En[r] ? view_data[r] : '0;
      end
    end
  endgenerate

endmodule

// File: tb/tb_regfile_pe_mp.sv
// Self-checking bench for regfile_pe_mp. Three instances share stimulus:
// registered+bypass, registered without bypass, combinational without bypass.
module tb_regfile_pe_mp;

  localparam int AW = 3;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NREGS = 8;

  logic             Clk = 1'b0;
  logic             Reset;
  logic [1:0]       we;
  logic [2*AW-1:0]  wa;
  logic [2*DW-1:0]  wd;
  logic [7:0]       wbe;
  logic [NR-1:0]    re;
  logic [NR*AW-1:0] ra;
  logic             clr;

  logic [NR*DW-1:0] rd_bp, rd_nb, rd_c;
  logic             busy_bp, busy_nb, busy_c;

  int checks = 0;
  int errors = 0;

  // Reference model: byte-addressed view of the file plus sweep position.
  logic [31:0] m_mem [NREGS];
  int          m_sweep;            // -1 when idle, else entry being cleared
  logic [31:0] m_bp [NR];
  logic [31:0] m_nb [NR];

  always #5 Clk = ~Clk;

  regfile_pe_mp #(.AWIDTH(AW), .DWIDTH(DW), .NUM_RD(NR), .REG_READ(1), .BYPASS(1)) dut (
    .Clk(Clk), .Reset(Reset), .Write_En(we), .Write_Addr(wa), .Write_Data(wd),
    .Write_BE(wbe), .Read_En(re), .Read_Addr(ra), .Read_Data(rd_bp),
    .Clear_Req(clr), .Clear_Busy(busy_bp));

  regfile_pe_mp #(.AWIDTH(AW), .DWIDTH(DW), .NUM_RD(NR), .REG_READ(1), .BYPASS(0)) dut_nb (
    .Clk(Clk), .Reset(Reset), .Write_En(we), .Write_Addr(wa), .Write_Data(wd),
    .Write_BE(wbe), .Read_En(re), .Read_Addr(ra), .Read_Data(rd_nb),
    .Clear_Req(clr), .Clear_Busy(busy_nb));

  regfile_pe_mp #(.AWIDTH(AW), .DWIDTH(DW), .NUM_RD(NR), .REG_READ(0), .BYPASS(0)) dut_c (
    .Clk(Clk), .Reset(Reset), .Write_En(we), .Write_Addr(wa), .Write_Data(wd),
    .Write_BE(wbe), .Read_En(re), .Read_Addr(ra), .Read_Data(rd_c),
    .Clear_Req(clr), .Clear_Busy(busy_c));

  typedef struct {
    logic [1:0]  we;
    logic [2:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [3:0]  be0, be1;
    logic [1:0]  re;
    logic [2:0]  ra0, ra1;
    logic [31:0] exp_bp0, exp_bp1, exp_nb0, exp_nb1;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    we = '0; wa = '0; wd = '0; wbe = '0; re = '0; ra = '0; clr = 1'b0;
  endtask

  task automatic set_wr(input int p, input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    we[p] = 1'b1;
    wa[p*AW +: AW] = a;
    wd[p*DW +: DW] = d;
    wbe[p*4 +: 4] = be;
  endtask

  task automatic set_rd(input int r, input logic en, input logic [2:0] a);
    re[r] = en;
    ra[r*AW +: AW] = a;
  endtask

  function automatic logic [2:0] raddr(input int r);
    return ra[r*AW +: AW];
  endfunction

  // One clock cycle: check combinational reads, advance model, check registers.
  task automatic step();
    logic [31:0] nm [NREGS];
    logic [2:0]  a;
    bit          busy;
    @(negedge Clk);
    for (int r = 0; r < NR; r++) begin
      a = raddr(r);
      check($sformatf("comb_rd%0d", r), rd_c[r*DW +: DW], re[r] ? m_mem[a] : 32'h0);
    end
    busy = (m_sweep >= 0);
    nm = m_mem;
    if (!busy) begin
      for (int p = 0; p < 2; p++)
        for (int b = 0; b < 4; b++)
          if (we[p] && wbe[p*4+b])
            nm[wa[p*AW +: AW]][b*8 +: 8] = wd[p*DW + b*8 +: 8];
    end
    for (int r = 0; r < NR; r++) begin
      a = raddr(r);
      if (re[r]) begin
        m_bp[r] = busy ? m_mem[a] : nm[a];
        m_nb[r] = m_mem[a];
      end
    end
    if (busy) begin
      nm[m_sweep] = '0;
      m_sweep++;
      if (m_sweep == NREGS) m_sweep = -1;
    end else if (clr) begin
      m_sweep = 0;
    end
    m_mem = nm;
    @(posedge Clk);
    #1;
    for (int r = 0; r < NR; r++) begin
      check($sformatf("bp_rd%0d", r), rd_bp[r*DW +: DW], m_bp[r]);
      check($sformatf("nb_rd%0d", r), rd_nb[r*DW +: DW], m_nb[r]);
    end
    check("busy_bp", {31'h0, busy_bp}, {31'h0, m_sweep >= 0});
    check("busy_nb", {31'h0, busy_nb}, {31'h0, m_sweep >= 0});
    check("busy_c",  {31'h0, busy_c},  {31'h0, m_sweep >= 0});
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
    for (int r = 0; r < NR; r++) begin
      m_bp[r] = '0;
      m_nb[r] = '0;
    end
    m_sweep = -1;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic apply_reset(input string tag);
    #2 Reset = 1'b1;
    #1;
    for (int r = 0; r < NR; r++) begin
      check({tag, "_rst_bp"}, rd_bp[r*DW +: DW], 32'h0);
      check({tag, "_rst_nb"}, rd_nb[r*DW +: DW], 32'h0);
      check({tag, "_rst_c"},  rd_c[r*DW +: DW],  32'h0);
    end
    check({tag, "_rst_busy"}, {29'h0, busy_bp, busy_nb, busy_c}, 32'h0);
    model_reset();
    set_idle();
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  task automatic fill();
    for (int i = 0; i < NREGS; i++) begin
      set_idle();
      set_wr(0, 3'(i), 32'h10 + 32'(i), 4'hF);
      step();
    end
    set_idle();
  endtask

  initial begin
    int n;
    int k;

    vecs[0] = '{2'b11, 3'd3, 3'd3, 32'h11111111, 32'hAAAAAAAA, 4'hF, 4'h3, 2'b01, 3'd3, 3'd0,
                32'h1111AAAA, 32'h0, 32'h0, 32'h0};
    vecs[1] = '{2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 4'h0, 4'h0, 2'b01, 3'd3, 3'd0,
                32'h1111AAAA, 32'h0, 32'h1111AAAA, 32'h0};
    vecs[2] = '{2'b01, 3'd5, 3'd0, 32'hDEADBEEF, 32'h0, 4'hF, 4'h0, 2'b01, 3'd5, 3'd0,
                32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    vecs[3] = '{2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 4'h0, 4'h0, 2'b10, 3'd0, 3'd3,
                32'hDEADBEEF, 32'h1111AAAA, 32'h0, 32'h1111AAAA};
    vecs[4] = '{2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00, 3'd1, 3'd5,
                32'hDEADBEEF, 32'h1111AAAA, 32'h0, 32'h1111AAAA};
    vecs[5] = '{2'b10, 3'd0, 3'd3, 32'h0, 32'hFFFFFFFF, 4'h0, 4'h0, 2'b00, 3'd1, 3'd0,
                32'hDEADBEEF, 32'h1111AAAA, 32'h0, 32'h1111AAAA};
    vecs[6] = '{2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 4'h0, 4'h0, 2'b11, 3'd3, 3'd5,
                32'h1111AAAA, 32'hDEADBEEF, 32'h1111AAAA, 32'hDEADBEEF};
    vecs[7] = '{2'b11, 3'd6, 3'd6, 32'h12345678, 32'hCAFEF00D, 4'hC, 4'h3, 2'b01, 3'd6, 3'd0,
                32'h1234F00D, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
    vecs[8] = '{2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 4'h0, 4'h0, 2'b01, 3'd6, 3'd0,
                32'h1234F00D, 32'hDEADBEEF, 32'h1234F00D, 32'hDEADBEEF};

    // Reset state.
    set_idle();
    model_reset();
    Reset = 1'b1;
    #1;
    check("init_rd_bp", rd_bp[31:0], 32'h0);
    check("init_busy", {31'h0, busy_bp}, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    // Directed table: byte merge, bypass, read hold, BE=0 no-op.
    for (int i = 0; i < 9; i++) begin
      set_idle();
      we = vecs[i].we;
      wa = {vecs[i].wa1, vecs[i].wa0};
      wd = {vecs[i].wd1, vecs[i].wd0};
      wbe = {vecs[i].be1, vecs[i].be0};
      re = vecs[i].re;
      ra = {vecs[i].ra1, vecs[i].ra0};
      step();
      check($sformatf("vec%0d_bp0", i), rd_bp[31:0],  vecs[i].exp_bp0);
      check($sformatf("vec%0d_bp1", i), rd_bp[63:32], vecs[i].exp_bp1);
      check($sformatf("vec%0d_nb0", i), rd_nb[31:0],  vecs[i].exp_nb0);
      check($sformatf("vec%0d_nb1", i), rd_nb[63:32], vecs[i].exp_nb1);
    end

    // Clear sweep: busy length, r7 visibility, write dropped during sweep.
    fill();
    clr = 1'b1;
    set_rd(0, 1'b1, 3'd7);
    step();
    n = 0;
    k = 0;
    while (busy_bp && k < 20) begin
      n++;
      set_idle();
      set_rd(0, 1'b1, 3'd7);
      if (k == 1) set_wr(0, 3'd2, 32'hFFFFFFFF, 4'hF);
      step();
      k++;
    end
    check("sweep_len", 32'(n), 32'd8);
    check("sweep_r7_last", rd_bp[31:0], 32'h17);
    set_idle();
    set_rd(0, 1'b1, 3'd7);
    set_rd(1, 1'b1, 3'd2);
    step();
    check("sweep_r7_after", rd_bp[31:0], 32'h0);
    check("sweep_write_lost", rd_bp[63:32], 32'h0);

    // Clear_Req during sweep does not extend it.
    fill();
    clr = 1'b1;
    step();
    n = 0;
    k = 0;
    while (busy_bp && k < 20) begin
      n++;
      set_idle();
      if (k == 3) clr = 1'b1;
      step();
      k++;
    end
    check("sweep_no_extend", 32'(n), 32'd8);

    // Write together with Clear_Req commits, then is erased by the sweep.
    fill();
    set_wr(1, 3'd4, 32'h55AA55AA, 4'hF);
    clr = 1'b1;
    step();
    for (int i = 0; i < NREGS; i++) begin
      set_idle();
      set_rd(1, 1'b1, 3'd4);
      step();
    end
    set_idle();
    set_rd(1, 1'b1, 3'd4);
    step();
    check("clr_wr_erased", rd_bp[63:32], 32'h0);

    // Reset mid-sweep aborts it.
    fill();
    clr = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      set_idle();
      step();
    end
    apply_reset("midsweep");
    for (int i = 0; i < NREGS; i += 2) begin
      set_idle();
      set_rd(0, 1'b1, 3'(i));
      set_rd(1, 1'b1, 3'(i+1));
      step();
      check("post_rst_rd0", rd_bp[31:0], 32'h0);
      check("post_rst_rd1", rd_bp[63:32], 32'h0);
    end

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      we  = 2'($urandom);
      wa  = 6'($urandom);
      wd  = {$urandom, $urandom};
      wbe = 8'($urandom);
      re  = 2'($urandom);
      ra  = 6'($urandom);
      if ($urandom_range(0, 3) == 0) ra[5:3] = wa[2:0];
      if ($urandom_range(0, 3) == 0) wa[5:3] = wa[2:0];
      clr = ($urandom_range(0, 29) == 0);
      step();
    end

    // Reset mid-run after random traffic.
    re = 2'b11;
    apply_reset("midrun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
